// File: rtl/seg7_decode_rx.sv
// Seven-segment bus receiver: debounces an active-low segment pattern, decodes it
// to a hex digit and presents it with a valid/ready handshake.
module seg7_decode_rx #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_i,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_code,
    output logic       out_dp,
    output logic       out_blank,
    output logic       out_err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] StabMax = 8'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e     state;
    logic [7:0] seg_q;
    logic [7:0] last_emit;
    logic [7:0] stab_cnt;
    logic       stable;
    logic [3:0] dec_code;
    logic       dec_blank;
    logic       dec_err;

    assign stable = (stab_cnt == StabMax);

    always_comb begin
        dec_code  = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_q[7:1])
            7'h01:   dec_code = 4'h0;
            7'h4F:   dec_code = 4'h1;
            7'h12:   dec_code = 4'h2;
            7'h06:   dec_code = 4'h3;
            7'h4C:   dec_code = 4'h4;
            7'h24:   dec_code = 4'h5;
            7'h20:   dec_code = 4'h6;
            7'h0F:   dec_code = 4'h7;
            7'h00:   dec_code = 4'h8;
            7'h04:   dec_code = 4'h9;
            7'h08:   dec_code = 4'hA;
            7'h60:   dec_code = 4'hB;
            7'h31:   dec_code = 4'hC;
            7'h42:   dec_code = 4'hD;
            7'h30:   dec_code = 4'hE;
            7'h38:   dec_code = 4'hF;
            7'h7F:   dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q     <= 8'hFF;
            last_emit <= 8'hFF;
            stab_cnt  <= 8'h00;
            state     <= StIdle;
            out_valid <= 1'b0;
            out_code  <= 4'h0;
            out_dp    <= 1'b0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            err_cnt   <= 8'h00;
        end else begin
            seg_q <= seg_i;
            // Filter keeps running in both states so a new pattern can be ready at handshake.
            if (seg_i != seg_q) begin
                stab_cnt <= 8'h00;
            end else if (stab_cnt != StabMax) begin
                stab_cnt <= stab_cnt + 8'h01;
            end

            case (state)
                StIdle: begin
                    if (stable && (seg_q != last_emit)) begin
                        state     <= StHold;
                        out_valid <= 1'b1;
                        out_code  <= dec_code;
                        out_dp    <= ~seg_q[0];
                        out_blank <= dec_blank;
                        out_err   <= dec_err;
                        last_emit <= seg_q;
                        if (dec_err && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'h01;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seg7_decode_rx.md
SEG7_DECODE_RX -- requirements
Module: seg7_decode_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples needed before a pattern is accepted; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-004 seg_i  input  8  active-low segment bus; [7:1] = segments a..g, [0] = dp; treated as synchronous to clk.
REQ-005 out_valid  output  1  a decoded character is presented.
REQ-006 out_ready  input  1  consumer accepts the character when high together with out_valid.
REQ-007 out_code  output  4  recovered hex digit.
REQ-008 out_dp  output  1  decimal point lit (seg_i[0] low in the accepted pattern).
REQ-009 out_blank  output  1  accepted pattern had all of a..g dark.
REQ-010 out_err  output  1  accepted pattern matched no glyph and was not blank.
REQ-011 err_cnt  output  8  saturating count of emitted error characters.

Function
REQ-012 The block SHALL register seg_i into seg_q every cycle; stab_cnt SHALL clear to 0 when seg_i != seg_q and otherwise increment, saturating at STABLE_CYCLES-1.
REQ-013 A pattern SHALL be stable when stab_cnt == STABLE_CYCLES-1; with seg_i first captured at edge k and held, out_valid SHALL rise after edge k+STABLE_CYCLES.
REQ-014 State machine: IDLE, HOLD; IDLE->HOLD on stable && seg_q != last_emit, latching decoded outputs, setting out_valid and loading last_emit <= seg_q in the same edge.
REQ-015 In HOLD, out_valid and all out_* SHALL stay constant until out_valid && out_ready; on that edge out_valid SHALL clear and state SHALL return to IDLE.
REQ-016 Filtering SHALL continue during HOLD; a pattern that became stable in HOLD SHALL be emitted no earlier than the edge after the handshake edge (one idle cycle minimum between characters).
REQ-017 A stable pattern equal to last_emit SHALL NOT be re-emitted; glitches shorter than STABLE_CYCLES SHALL never be emitted.
REQ-018 Glyph table on seg_q[7:1] (full 8-bit active-low form in brackets): 0=7'h01[02] 1=4F[9F] 2=12[25] 3=06[0D] 4=4C[99] 5=24[49] 6=20[41] 7=0F[1F] 8=00[01] 9=04[09] A=08[11] B=60[C1] C=31[63] D=42[85] E=30[61] F=38[71].
REQ-019 Digit 0's canonical encoding has dp lit; out_dp SHALL report ~seg_q[0] independently of the glyph match, so 8'h02 yields code 0, dp 1.
REQ-020 seg_q[7:1] == 7'h7F SHALL emit out_blank=1, out_code=0, out_err=0; any non-table, non-blank value SHALL emit out_err=1, out_code=0, out_blank=0.
REQ-021 err_cnt SHALL increment on the IDLE->HOLD edge of each error character and saturate at 8'hFF.
REQ-022 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-023 While rst_n is low: seg_q=8'hFF, last_emit=8'hFF, stab_cnt=0, state=IDLE, out_valid=0, out_code=0, out_dp=0, out_blank=0, out_err=0, err_cnt=0.
REQ-024 Reset asserted in HOLD SHALL drop out_valid immediately without clock; the held character is discarded.
REQ-025 After reset, an all-dark bus (8'hFF) SHALL NOT emit a character, since it equals last_emit.

Verification (STABLE_CYCLES=4)
REQ-026 Reset, seg_i=8'h25 held, out_ready=1 -> out_valid one cycle, 4 edges after capture, code=2, dp=0, blank=0, err=0.
REQ-027 seg_i=8'h02 held, out_ready=0 for 10 cycles -> out_valid high, code=0, dp=1 held unchanged until out_ready=1; single handshake only.
REQ-028 Emit 8'h9F, then 8'h25 for 2 cycles, then 8'h9F again -> no further character emitted.
REQ-029 seg_i=8'hAA (no glyph) then 8'hFF, each held 6 cycles, out_ready=1 -> err char (err_cnt=1), then blank char; 256 alternating err/valid pairs -> err_cnt stops at 8'hFF.
REQ-030 out_valid high in HOLD, rst_n pulsed low mid-cycle -> out_valid low before next edge; after release, previous pattern re-held 4 cycles -> re-emitted.
REQ-031 8'h0D stable and emitted with out_ready=0, seg_i switches to 8'h11 during HOLD -> code 3 held; handshake edge, then code A presented after one low cycle of out_valid.
